// File: rtl/reg_file_scoreboard_pkg.sv
// Shared sizing constants for the architectural register file and its busy scoreboard.
package reg_file_scoreboard_pkg;

    localparam int DATA_W   = 32;
    localparam int ADDR_W   = 5;
    localparam int NUM_REGS = 2 ** ADDR_W;
    localparam int ZERO_REG = 0;

endpackage

// File: rtl/reg_file_scoreboard_if.sv
// Decode/write-back facing bus of the register file: operand read, issue and write-back.
interface reg_file_scoreboard_if #(
    parameter int DATA_W = reg_file_scoreboard_pkg::DATA_W,
    parameter int ADDR_W = reg_file_scoreboard_pkg::ADDR_W
);

    logic              rd_req;
    logic [ADDR_W-1:0] rs_addr;
    logic [ADDR_W-1:0] rt_addr;
    logic              rd_stall;
    logic              rd_valid;
    logic [DATA_W-1:0] rs_data;
    logic [DATA_W-1:0] rt_data;
    logic              issue_en;
    logic [ADDR_W-1:0] issue_dst;
    logic              wr_en;
    logic [ADDR_W-1:0] wr_addr;
    logic [DATA_W-1:0] wr_data;

    modport master (
        output rd_req, rs_addr, rt_addr, issue_en, issue_dst, wr_en, wr_addr, wr_data,
        input  rd_stall, rd_valid, rs_data, rt_data
    );

    modport slave (
        input  rd_req, rs_addr, rt_addr, issue_en, issue_dst, wr_en, wr_addr, wr_data,
        output rd_stall, rd_valid, rs_data, rt_data
    );

endinterface

// File: rtl/reg_file_scoreboard_busy_scoreboard.sv
// Per-register busy flags: set on issue, cleared on write-back, with a same-cycle
// write-back hiding the hazard for the two query ports.
module busy_scoreboard #(
    parameter int ADDR_W   = reg_file_scoreboard_pkg::ADDR_W,
    parameter int NUM_REGS = reg_file_scoreboard_pkg::NUM_REGS
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              issue_en,
    input  logic [ADDR_W-1:0] issue_dst,
    input  logic              wr_en,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [ADDR_W-1:0] qa_addr,
    input  logic [ADDR_W-1:0] qb_addr,
    output logic              qa_busy,
    output logic              qb_busy
);

    import reg_file_scoreboard_pkg::*;

    logic [NUM_REGS-1:0] busy;
    logic                wr_live;
    logic                issue_live;

    assign wr_live    = wr_en && (wr_addr != ADDR_W'(ZERO_REG));
    assign issue_live = issue_en && (issue_dst != ADDR_W'(ZERO_REG));

    // Issue is applied after the clear so a newer producer keeps the register busy.
    always_ff @(posedge clk) begin
        if (rst) begin
            busy <= '0;
        end else begin
            if (wr_live) begin
                busy[wr_addr] <= 1'b0;
            end
            if (issue_live) begin
                busy[issue_dst] <= 1'b1;
            end
        end
    end

    assign qa_busy = busy[qa_addr] && !(wr_en && (wr_addr == qa_addr));
    assign qb_busy = busy[qb_addr] && !(wr_en && (wr_addr == qb_addr));

endmodule

// File: rtl/reg_file_scoreboard.sv
// Architectural register file with two registered read ports, write-back bypass
// and a busy scoreboard that stalls decode until pending producers land.
module reg_file_scoreboard #(
    parameter int DATA_W   = reg_file_scoreboard_pkg::DATA_W,
    parameter int ADDR_W   = reg_file_scoreboard_pkg::ADDR_W,
    parameter int NUM_REGS = reg_file_scoreboard_pkg::NUM_REGS
) (
    input logic                  clk,
    input logic                  rst,
    reg_file_scoreboard_if.slave bus
);

    import reg_file_scoreboard_pkg::*;

    logic [DATA_W-1:0] regs [NUM_REGS];
    logic              rs_busy;
    logic              rt_busy;
    logic              stall;
    logic              fire;
    logic              wr_live;
    logic [DATA_W-1:0] rs_next;
    logic [DATA_W-1:0] rt_next;
    logic              valid_q;
    logic [DATA_W-1:0] rs_q;
    logic [DATA_W-1:0] rt_q;

    busy_scoreboard #(
        .ADDR_W   (ADDR_W),
        .NUM_REGS (NUM_REGS)
    ) u_busy (
        .clk       (clk),
        .rst       (rst),
        .issue_en  (bus.issue_en),
        .issue_dst (bus.issue_dst),
        .wr_en     (bus.wr_en),
        .wr_addr   (bus.wr_addr),
        .qa_addr   (bus.rs_addr),
        .qb_addr   (bus.rt_addr),
        .qa_busy   (rs_busy),
        .qb_busy   (rt_busy)
    );

    assign stall   = bus.rd_req && (rs_busy || rt_busy);
    assign fire    = bus.rd_req && !stall;
    assign wr_live = bus.wr_en && (bus.wr_addr != ADDR_W'(ZERO_REG));

    // Operand select: register 0 reads zero, otherwise a same-cycle write-back wins.
    always_comb begin
        rs_next = '0;
        rt_next = '0;
        if (bus.rs_addr != ADDR_W'(ZERO_REG)) begin
            rs_next = (wr_live && (bus.wr_addr == bus.rs_addr)) ? bus.wr_data : regs[bus.rs_addr];
        end
        if (bus.rt_addr != ADDR_W'(ZERO_REG)) begin
            rt_next = (wr_live && (bus.wr_addr == bus.rt_addr)) ? bus.wr_data : regs[bus.rt_addr];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            valid_q <= 1'b0;
            rs_q    <= '0;
            rt_q    <= '0;
            for (int unsigned i = 0; i < NUM_REGS; i++) begin
                regs[i] <= '0;
            end
        end else begin
            valid_q <= fire;
            if (fire) begin
                rs_q <= rs_next;
                rt_q <= rt_next;
            end
            if (wr_live) begin
                regs[bus.wr_addr] <= bus.wr_data;
            end
        end
    end

    assign bus.rd_stall = stall;
    assign bus.rd_valid = valid_q;
    assign bus.rs_data  = rs_q;
    assign bus.rt_data  = rt_q;

endmodule

// File: tb/tb_reg_file_scoreboard.sv
// Directed, table-driven bench for reg_file_scoreboard with hand-computed expectations.
module tb_reg_file_scoreboard;

    logic clk;
    logic rst;
    int   checks;
    int   failures;

    reg_file_scoreboard_if #(.DATA_W(32), .ADDR_W(5)) bus ();

    reg_file_scoreboard #(
        .DATA_W   (32),
        .ADDR_W   (5),
        .NUM_REGS (32)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic        rd_req;
        logic [4:0]  rs;
        logic [4:0]  rt;
        logic        ie;
        logic [4:0]  idst;
        logic        we;
        logic [4:0]  wa;
        logic [31:0] wd;
        logic        exp_stall;
        logic        exp_valid;
        logic [31:0] exp_rs;
        logic [31:0] exp_rt;
    } vec_t;

    vec_t tv[$];

    task automatic addv(input logic r, input logic rq, input logic [4:0] rs, input logic [4:0] rt,
                        input logic ie, input logic [4:0] idst, input logic we, input logic [4:0] wa,
                        input logic [31:0] wd, input logic es, input logic ev,
                        input logic [31:0] ers, input logic [31:0] ert);
        vec_t v;
        v = '{r, rq, rs, rt, ie, idst, we, wa, wd, es, ev, ers, ert};
        tv.push_back(v);
    endtask

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got=%h expected=%h", name, got, exp);
        end
    endtask

    task automatic drive(input logic r, input logic rq, input logic [4:0] rs, input logic [4:0] rt,
                         input logic ie, input logic [4:0] idst, input logic we, input logic [4:0] wa,
                         input logic [31:0] wd);
        rst           = r;
        bus.rd_req    = rq;
        bus.rs_addr   = rs;
        bus.rt_addr   = rt;
        bus.issue_en  = ie;
        bus.issue_dst = idst;
        bus.wr_en     = we;
        bus.wr_addr   = wa;
        bus.wr_data   = wd;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        checks   = 0;
        failures = 0;
        drive(1'b1, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);

        //    rst rq rs  rt  ie id  we wa  wd            stall vld rs_data       rt_data
        addv(1, 0, 0,  0,  0, 0,  0, 0,  32'h0,        0, 0, 32'h0,        32'h0);
        addv(0, 0, 0,  0,  0, 0,  1, 5,  32'hDEADBEEF, 0, 0, 32'h0,        32'h0);
        addv(1, 1, 5,  0,  1, 6,  0, 0,  32'h0,        0, 0, 32'h0,        32'h0);
        addv(0, 1, 5,  6,  0, 0,  0, 0,  32'h0,        0, 1, 32'h0,        32'h0);
        addv(0, 0, 0,  0,  0, 0,  1, 7,  32'h12345678, 0, 0, 32'h0,        32'h0);
        addv(0, 1, 7,  0,  0, 0,  0, 0,  32'h0,        0, 1, 32'h12345678, 32'h0);
        addv(0, 0, 0,  0,  1, 9,  0, 0,  32'h0,        0, 0, 32'h12345678, 32'h0);
        addv(0, 1, 9,  0,  0, 0,  0, 0,  32'h0,        1, 0, 32'h12345678, 32'h0);
        addv(0, 1, 9,  0,  0, 0,  0, 0,  32'h0,        1, 0, 32'h12345678, 32'h0);
        addv(0, 1, 9,  0,  0, 0,  0, 0,  32'h0,        1, 0, 32'h12345678, 32'h0);
        addv(0, 1, 9,  0,  0, 0,  1, 9,  32'hA5A5A5A5, 0, 1, 32'hA5A5A5A5, 32'h0);
        addv(0, 0, 0,  0,  1, 0,  1, 0,  32'hFFFFFFFF, 0, 0, 32'hA5A5A5A5, 32'h0);
        addv(0, 1, 0,  0,  0, 0,  0, 0,  32'h0,        0, 1, 32'h0,        32'h0);
        addv(0, 0, 0,  0,  1, 4,  0, 0,  32'h0,        0, 0, 32'h0,        32'h0);
        addv(0, 0, 0,  0,  1, 4,  1, 4,  32'h11,       0, 0, 32'h0,        32'h0);
        addv(0, 1, 4,  7,  0, 0,  0, 0,  32'h0,        1, 0, 32'h0,        32'h0);
        addv(0, 1, 4,  7,  0, 0,  0, 0,  32'h0,        1, 0, 32'h0,        32'h0);
        addv(0, 1, 4,  7,  0, 0,  1, 4,  32'h22,       0, 1, 32'h22,       32'h12345678);
        addv(0, 1, 3,  3,  1, 3,  0, 0,  32'h0,        0, 1, 32'h0,        32'h0);
        addv(0, 1, 3,  0,  0, 0,  0, 0,  32'h0,        1, 0, 32'h0,        32'h0);
        addv(0, 1, 7,  3,  0, 0,  1, 3,  32'h33,       0, 1, 32'h12345678, 32'h33);
        addv(0, 1, 3,  9,  0, 0,  0, 0,  32'h0,        0, 1, 32'h33,       32'hA5A5A5A5);
        addv(0, 1, 4,  0,  0, 0,  0, 0,  32'h0,        0, 1, 32'h22,       32'h0);
        addv(0, 1, 7,  7,  0, 0,  1, 7,  32'h77,       0, 1, 32'h77,       32'h77);
        addv(0, 1, 7,  4,  0, 0,  0, 0,  32'h0,        0, 1, 32'h77,       32'h22);
        addv(0, 0, 0,  0,  1, 10, 0, 0,  32'h0,        0, 0, 32'h77,       32'h22);
        addv(0, 1, 0,  10, 0, 0,  0, 0,  32'h0,        1, 0, 32'h77,       32'h22);
        addv(0, 0, 10, 0,  0, 0,  0, 0,  32'h0,        0, 0, 32'h77,       32'h22);

        foreach (tv[i]) begin
            @(negedge clk);
            drive(tv[i].rst, tv[i].rd_req, tv[i].rs, tv[i].rt, tv[i].ie, tv[i].idst,
                  tv[i].we, tv[i].wa, tv[i].wd);
            #1;
            check($sformatf("v%0d_stall", i), 32'(bus.rd_stall), 32'(tv[i].exp_stall));
            @(posedge clk);
            #1;
            check($sformatf("v%0d_valid", i), 32'(bus.rd_valid), 32'(tv[i].exp_valid));
            check($sformatf("v%0d_rs_data", i), bus.rs_data, tv[i].exp_rs);
            check($sformatf("v%0d_rt_data", i), bus.rt_data, tv[i].exp_rt);
        end

        // Held request on a busy register, released by a write-back in its third cycle.
        begin
            int  n;
            bit  seen;
            @(negedge clk);
            drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd12, 1'b0, 5'd0, 32'h0);
            @(posedge clk);
            n    = 0;
            seen = 1'b0;
            while (!seen && n < 8) begin
                @(negedge clk);
                drive(1'b0, 1'b1, 5'd12, 5'd0, 1'b0, 5'd0, (n == 2), 5'd12, 32'hCAFEF00D);
                @(posedge clk);
                #1;
                if (bus.rd_valid === 1'b1) seen = 1'b1;
                else n++;
            end
            check("hs_valid_seen", 32'(seen), 32'd1);
            check("hs_latency", n, 32'd2);
            check("hs_data", bus.rs_data, 32'hCAFEF00D);
        end

        // Reset while a busy register is being requested clears the hazard.
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b1, 5'd13, 1'b0, 5'd0, 32'h0);
        @(negedge clk);
        drive(1'b1, 1'b1, 5'd13, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        #1;
        check("rs_busy_before_rst_stall", 32'(bus.rd_stall), 32'd1);
        @(posedge clk);
        #1;
        check("rs_rst_valid", 32'(bus.rd_valid), 32'd0);
        @(negedge clk);
        drive(1'b0, 1'b1, 5'd13, 5'd12, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        #1;
        check("rs_after_rst_stall", 32'(bus.rd_stall), 32'd0);
        @(posedge clk);
        #1;
        check("rs_after_rst_valid", 32'(bus.rd_valid), 32'd1);
        check("rs_after_rst_rt_data", bus.rt_data, 32'h0);
        @(negedge clk);
        drive(1'b0, 1'b0, 5'd0, 5'd0, 1'b0, 5'd0, 1'b0, 5'd0, 32'h0);
        @(posedge clk);
        #1;
        check("rs_single_cycle_valid", 32'(bus.rd_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
